// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file: FSM state
// encodings, a constant clog2 helper and the core's default geometry.
package regfile_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Per-cycle write-port resolution: picks one winning port per address (highest
// index wins), drops zero-register writes and flags same-address clashes.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int AW       = 5,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  output logic [NUM_WR-1:0]    wr_win,
  output logic                 clash
);

  logic [NUM_WR-1:0] live;
  logic [NUM_WR-1:0] beaten;

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_port
    logic [AW-1:0] addr;
    logic          beaten_bit;

    assign addr     = wr_addr[gi*AW +: AW];
    assign live[gi] = wr_en[gi] && !((ZERO_REG != 0) && (addr == '0));

    // A port loses when any higher-indexed live port targets the same entry.
    always_comb begin
      beaten_bit = 1'b0;
      for (int k = gi + 1; k < NUM_WR; k++) begin
        if (live[k] && (wr_addr[k*AW +: AW] == addr)) beaten_bit = 1'b1;
      end
    end

    assign beaten[gi] = beaten_bit;
    assign wr_win[gi] = live[gi] && !beaten_bit;
  end

  // Any live port that was out-prioritised implies two ports hit one address.
  assign clash = |(live & beaten);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage: async reads, sync writes,
// optional bypass and zero register, contents cleared by a hardware sweep.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_req,
  output logic                 busy,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR*DW-1:0] wr_data,
  output logic                 wr_conflict
);

  state_t         state_reg;
  logic [AW-1:0]  sweep_ptr_reg;
  logic           busy_reg;
  logic           wr_conflict_reg;
  logic           ready;
  logic [NUM_WR-1:0] wr_win;
  logic           clash;

  logic [DW-1:0]  mem [DEPTH];

  assign ready = (state_reg == ST_READY);

  regfile_wr_arb #(
    .AW       (AW),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_wr_arb (
    .wr_en   (wr_en & {NUM_WR{ready}}),
    .wr_addr (wr_addr),
    .wr_win  (wr_win),
    .clash   (clash)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_CLEAR;
      sweep_ptr_reg   <= '0;
      busy_reg        <= 1'b1;
      wr_conflict_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          sweep_ptr_reg   <= sweep_ptr_reg + 1'b1;
          wr_conflict_reg <= 1'b0;
          if (sweep_ptr_reg == AW'(DEPTH - 1)) begin
            state_reg <= ST_READY;
            busy_reg  <= 1'b0;
          end
        end
        ST_READY: begin
          wr_conflict_reg <= clash;
          if (clear_req) begin
            state_reg     <= ST_CLEAR;
            sweep_ptr_reg <= '0;
            busy_reg      <= 1'b1;
          end
        end
        default: begin
          state_reg       <= ST_CLEAR;
          sweep_ptr_reg   <= '0;
          busy_reg        <= 1'b1;
          wr_conflict_reg <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep owns the write path while clearing.
  always_ff @(posedge clk) begin
    if (state_reg == ST_CLEAR) begin
      mem[sweep_ptr_reg] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_win[j]) mem[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          byp_hit;
    logic [DW-1:0] byp_data;

    assign addr = rd_addr[gi*AW +: AW];

    // Winners have unique addresses, so at most one port can match here.
    always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_win[j] && (wr_addr[j*AW +: AW] == addr)) begin
            byp_hit  = 1'b1;
            byp_data = wr_data[j*DW +: DW];
          end
        end
      end
    end

    assign rd_data[gi*DW +: DW] = busy_reg                             ? '0 :
                                  ((ZERO_REG != 0) && (addr == '0))    ? '0 :
                                  byp_hit                              ? byp_data :
                                                                         mem[addr];
  end

  assign busy        = busy_reg;
  assign wr_conflict = wr_conflict_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: a bypass/zero-reg build and a plain build
// share stimulus and are checked against an array-based reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear_req;
  logic [NR*AW-1:0]  rd_addr;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              busy_a, busy_b, conf_a, conf_b;
  logic [NR*DW-1:0]  rd_data_a, rd_data_b;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  int            busy_cnt;
  logic          exp_conf_a, exp_conf_b;

  always #5 clk = ~clk;

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1), .ZERO_REG(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_a),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_conflict(conf_a)
  );

  regfile_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0), .ZERO_REG(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy_b),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_conflict(conf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_busy();
    return !rst_n || (busy_cnt > 0);
  endfunction

  function automatic logic [DW-1:0] exp_read(input bit is_a, input logic [AW-1:0] a);
    if (exp_busy()) return '0;
    if (!is_a) return mem_b[a];
    if (a == 0) return '0;
    for (int j = NW - 1; j >= 0; j--)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) return wr_data[j*DW +: DW];
    return mem_a[a];
  endfunction

  task automatic model_edge();
    logic [AW-1:0] aj;
    if (!rst_n) begin
      busy_cnt = DEPTH; exp_conf_a = 1'b0; exp_conf_b = 1'b0;
    end else if (busy_cnt > 0) begin
      mem_a[DEPTH - busy_cnt] = '0;
      mem_b[DEPTH - busy_cnt] = '0;
      busy_cnt--;
      exp_conf_a = 1'b0; exp_conf_b = 1'b0;
    end else begin
      exp_conf_a = 1'b0; exp_conf_b = 1'b0;
      for (int j = 0; j < NW; j++) begin
        aj = wr_addr[j*AW +: AW];
        for (int k = j + 1; k < NW; k++)
          if (wr_en[j] && wr_en[k] && wr_addr[k*AW +: AW] == aj) begin
            exp_conf_b = 1'b1;
            if (aj != 0) exp_conf_a = 1'b1;
          end
      end
      for (int j = 0; j < NW; j++) begin
        aj = wr_addr[j*AW +: AW];
        if (wr_en[j]) begin
          mem_b[aj] = wr_data[j*DW +: DW];
          if (aj != 0) mem_a[aj] = wr_data[j*DW +: DW];
        end
      end
      if (clear_req) busy_cnt = DEPTH;
    end
  endtask

  // One clock: check reads before the edge, update model, check flops after it.
  task automatic step();
    logic [AW-1:0] a;
    #1;
    for (int i = 0; i < NR; i++) begin
      a = rd_addr[i*AW +: AW];
      check($sformatf("rdA%0d", i), rd_data_a[i*DW +: DW], exp_read(1'b1, a));
      check($sformatf("rdB%0d", i), rd_data_b[i*DW +: DW], exp_read(1'b0, a));
    end
    check("busyA_pre", busy_a, exp_busy());
    check("busyB_pre", busy_b, exp_busy());
    @(posedge clk);
    model_edge();
    #1;
    check("busyA", busy_a, exp_busy());
    check("busyB", busy_b, exp_busy());
    check("confA", conf_a, exp_conf_a);
    check("confB", conf_b, exp_conf_b);
    $display("t=%0t rst_n=%b clr=%b we=%b wa=%h wd=%h ra=%h busy=%b conf=%b/%b",
             $time, rst_n, clear_req, wr_en, wr_addr, wr_data, rd_addr, busy_a, conf_a, conf_b);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = '0; clear_req = 1'b0;
  endtask

  task automatic count_busy(input string tag);
    int cnt;
    cnt = 0;
    while (busy_a && cnt < 100) begin
      cnt++;
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      step();
    end
    check(tag, cnt, DEPTH);
  endtask

  task automatic read_all_zero();
    idle();
    for (int a = 0; a < DEPTH; a += 2) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      #1;
      check("zeroA0", rd_data_a[DW-1:0], 32'h0);
      check("zeroB1", rd_data_b[2*DW-1:DW], 32'h0);
      step();
    end
  endtask

  task automatic rand_writes();
    for (int j = 0; j < NW; j++) begin
      wr_en[j] = 1'($urandom);
      wr_addr[j*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      wr_data[j*DW +: DW] = $urandom;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    busy_cnt = DEPTH; exp_conf_a = 1'b0; exp_conf_b = 1'b0;
    rst_n = 1'b0; clear_req = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    @(negedge clk);
    check("rst_busy", busy_a, 1'b1);
    check("rst_conf", conf_a, 1'b0);
    step(); step();

    // Reset release: busy exactly DEPTH cycles, then everything reads zero.
    rst_n = 1'b1;
    count_busy("busy_len_reset");
    read_all_zero();

    // Bypass vs plain build on a single write.
    wr_en = 2'b01; wr_addr = {AW'(0), AW'(5)}; wr_data = {32'h0, 32'hDEADBEEF};
    rd_addr = {AW'(5), AW'(5)};
    #1;
    check("byp_same", rd_data_a[DW-1:0], 32'hDEADBEEF);
    check("nob_same", rd_data_b[DW-1:0], 32'h0);
    step();
    idle();
    #1;
    check("nob_next", rd_data_b[DW-1:0], 32'hDEADBEEF);
    step();

    // Two ports on r7: port 1 wins, conflict flagged for one cycle.
    wr_en = 2'b11; wr_addr = {AW'(7), AW'(7)}; wr_data = {32'h22, 32'h11};
    rd_addr = {AW'(7), AW'(7)};
    step();
    idle();
    check("r7_conf", conf_a, 1'b1);
    #1;
    check("r7_val", rd_data_a[DW-1:0], 32'h22);
    step();
    check("r7_conf_drop", conf_a, 1'b0);

    // Zero register: both ports hit r0; bypass build ignores it entirely.
    wr_en = 2'b11; wr_addr = '0; wr_data = {32'hFFFFFFFF, 32'hFFFFFFFF}; rd_addr = '0;
    step();
    idle();
    check("r0_noconf", conf_a, 1'b0);
    check("r0_confB", conf_b, 1'b1);
    step();

    // Randomised traffic with occasional clear requests.
    for (int n = 0; n < 400; n++) begin
      rand_writes();
      clear_req = ($urandom_range(0, 49) == 0);
      rd_addr = ($urandom_range(0, 2) == 0) ? wr_addr : NR*AW'($urandom);
      step();
    end
    idle();
    while (busy_a) step();

    // Fill r1..r31, then clear with writes attempted throughout the sweep.
    for (int a = 1; a < DEPTH; a++) begin
      wr_en = 2'b10; wr_addr = {AW'(a), AW'(0)}; wr_data = {$urandom, 32'h0};
      rd_addr = {AW'(a - 1), AW'(a)};
      step();
    end
    idle();
    clear_req = 1'b1; wr_en = 2'b01; wr_addr = {AW'(0), AW'(9)}; wr_data = {32'h0, 32'h12345678};
    step();
    clear_req = 1'b0;
    for (int n = 0; n < 200 && busy_a; n++) begin
      rand_writes();
      rd_addr = NR*AW'($urandom);
      step();
    end
    check("clear_done", busy_a, 1'b0);
    read_all_zero();

    // Reset mid-sweep at sweep_ptr=10 restarts the full sweep.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    count_busy("busy_len_midrst");
    read_all_zero();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
